// File: rtl/kernel_job_scheduler.sv
// kernel_job_scheduler
// Queues job descriptor addresses and dispatches each to an idle kernel,
// picking among idle kernels round-robin. Tracks per-kernel busy state from
// rising completion edges and counts finished jobs.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   manager_start    dispatch enable (level)
//   job_valid        job submission valid
//   job_ready        queue can accept a job (= !full, registered)
//   job_addr         submitted descriptor address
//   kernel_start     one-hot, single-cycle start pulse
//   kernel_job_addr  descriptor address for the started kernel, held until next grant
//   kernel_complete  per-kernel done level; rising edge = job finished
//   kernel_busy      kernel owns a job
//   queue_level      number of queued jobs
//   jobs_done_cnt    completed-job counter (wraps)
//   all_idle         queue empty, no kernel busy, FSM idle
module kernel_job_scheduler #(
    parameter int unsigned KERNEL_NUM = 8,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            manager_start,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [ADDR_W-1:0]               job_addr,
    output logic [KERNEL_NUM-1:0]           kernel_start,
    output logic [ADDR_W-1:0]               kernel_job_addr,
    input  logic [KERNEL_NUM-1:0]           kernel_complete,
    output logic [KERNEL_NUM-1:0]           kernel_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] queue_level,
    output logic [31:0]                     jobs_done_cnt,
    output logic                            all_idle
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned KW    = $clog2(KERNEL_NUM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [KW-1:0]           grant_q;
    logic [KW-1:0]           grant_c;
    logic [KW-1:0]           rr_ptr;
    logic [KERNEL_NUM-1:0]   complete_prev;

    logic                    push;
    logic                    pop;
    logic [LVL_W-1:0]        level_next;
    logic [KERNEL_NUM-1:0]   comp_edge;
    logic [KERNEL_NUM-1:0]   counted;
    logic [KERNEL_NUM-1:0]   busy_next;
    logic [31:0]             done_inc;

    // Queue occupancy bookkeeping; job_ready already excludes pushes when full
    always_comb begin : queue_next
        push       = job_valid & job_ready;
        pop        = (state == S_GRANT);
        level_next = queue_level;
        if (push && !pop) begin
            level_next = queue_level + LVL_W'(1);
        end else if (!push && pop) begin
            level_next = queue_level - LVL_W'(1);
        end
    end

    // Completion edges count only for kernels that currently own a job
    always_comb begin : completion_next
        comp_edge = ~complete_prev & kernel_complete;
        counted   = comp_edge & kernel_busy;
        busy_next = kernel_busy & ~counted;
        if (state == S_ISSUE) begin
            busy_next = busy_next | (KERNEL_NUM'(1) << grant_q);
        end
        done_inc = '0;
        for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
            done_inc = done_inc + 32'(counted[i]);
        end
    end

    // Round-robin search: first idle kernel at or above rr_ptr, wrapping
    always_comb begin : grant_search
        int unsigned idx;
        logic        found;
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= KERNEL_NUM) begin
                idx = idx - KERNEL_NUM;
            end
            if (!found && !kernel_busy[KW'(idx)]) begin
                found   = 1'b1;
                grant_c = KW'(idx);
            end
        end
    end

    // Dispatch sequencing
    always_comb begin : fsm_next
        state_next = state;
        case (state)
            S_IDLE: begin
                if (manager_start && (queue_level != '0) && !(&kernel_busy)) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: state_next = S_ISSUE;
            S_ISSUE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Queue storage; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= job_addr;
        end
    end

    // State, queue pointers, dispatch outputs, busy tracking and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            queue_level     <= '0;
            job_ready       <= 1'b1;
            grant_q         <= '0;
            rr_ptr          <= '0;
            kernel_start    <= '0;
            kernel_job_addr <= '0;
            kernel_busy     <= '0;
            complete_prev   <= '1;
            jobs_done_cnt   <= '0;
            all_idle        <= 1'b1;
        end else begin
            state         <= state_next;
            queue_level   <= level_next;
            job_ready     <= (level_next != LVL_W'(FIFO_DEPTH));
            kernel_busy   <= busy_next;
            complete_prev <= kernel_complete;
            jobs_done_cnt <= jobs_done_cnt + done_inc;
            all_idle      <= (level_next == '0) && (busy_next == '0) && (state_next == S_IDLE);
            kernel_start  <= '0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // Grant is latched here so the pulse lands in the ISSUE cycle
            if (state == S_GRANT) begin
                grant_q         <= grant_c;
                kernel_job_addr <= mem[rd_ptr];
                kernel_start    <= KERNEL_NUM'(1) << grant_c;
            end

            if (state == S_ISSUE) begin
                rr_ptr <= (grant_q == KW'(KERNEL_NUM - 1)) ? '0 : grant_q + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_kernel_job_scheduler.sv
// Directed self-checking bench for kernel_job_scheduler (8 kernels, 64-bit
// addresses, 16-entry queue). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_kernel_job_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        manager_start;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] job_addr;
    logic [7:0]  kernel_start;
    logic [63:0] kernel_job_addr;
    logic [7:0]  kernel_complete;
    logic [7:0]  kernel_busy;
    logic [4:0]  queue_level;
    logic [31:0] jobs_done_cnt;
    logic        all_idle;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    kernel_job_scheduler #(
        .KERNEL_NUM (8),
        .ADDR_W     (64),
        .FIFO_DEPTH (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .manager_start   (manager_start),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_addr        (job_addr),
        .kernel_start    (kernel_start),
        .kernel_job_addr (kernel_job_addr),
        .kernel_complete (kernel_complete),
        .kernel_busy     (kernel_busy),
        .queue_level     (queue_level),
        .jobs_done_cnt   (jobs_done_cnt),
        .all_idle        (all_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset(input logic [7:0] comp);
        rst             = 1'b1;
        manager_start   = 1'b0;
        job_valid       = 1'b0;
        job_addr        = '0;
        kernel_complete = comp;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_job(input logic [63:0] a);
        job_valid = 1'b1;
        job_addr  = a;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic pulse_complete(input logic [7:0] m);
        kernel_complete = m;
        @(negedge clk);
        kernel_complete = '0;
    endtask

    // Bounded wait for the next start pulse; reports what it saw
    task automatic wait_start(output logic [7:0] ks, output logic [63:0] a,
                              output int at, output bit to);
        int n;
        ks = '0;
        a  = '0;
        at = 0;
        to = 1'b1;
        n  = 0;
        while (to && n < 40) begin
            @(negedge clk);
            n++;
            if (kernel_start !== 8'h00) begin
                ks = kernel_start;
                a  = kernel_job_addr;
                at = cyc;
                to = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset(8'h00);
        nchk++; if (job_ready !== 1'b1) begin nerr++; $display("FAIL reset_job_ready: got %0h want 1", job_ready); end
        nchk++; if (kernel_start !== 8'h00) begin nerr++; $display("FAIL reset_kernel_start: got %0h want 0", kernel_start); end
        nchk++; if (kernel_job_addr !== 64'h0) begin nerr++; $display("FAIL reset_job_addr: got %0h want 0", kernel_job_addr); end
        nchk++; if (kernel_busy !== 8'h00) begin nerr++; $display("FAIL reset_busy: got %0h want 0", kernel_busy); end
        nchk++; if (queue_level !== 5'd0) begin nerr++; $display("FAIL reset_queue_level: got %0d want 0", queue_level); end
        nchk++; if (jobs_done_cnt !== 32'd0) begin nerr++; $display("FAIL reset_done_cnt: got %0d want 0", jobs_done_cnt); end
        nchk++; if (all_idle !== 1'b1) begin nerr++; $display("FAIL reset_all_idle: got %0h want 1", all_idle); end
    endtask

    task automatic test_single_dispatch();
        do_reset(8'h00);
        manager_start = 1'b1;
        push_job(64'h1000);
        nchk++; if (queue_level !== 5'd1) begin nerr++; $display("FAIL single_level: got %0d want 1", queue_level); end
        nchk++; if (kernel_start !== 8'h00) begin nerr++; $display("FAIL single_early0: got %0h want 0", kernel_start); end
        @(negedge clk);
        nchk++; if (kernel_start !== 8'h00) begin nerr++; $display("FAIL single_early1: got %0h want 0", kernel_start); end
        @(negedge clk);
        nchk++; if (kernel_start !== 8'h01) begin nerr++; $display("FAIL single_start: got %0h want 01", kernel_start); end
        nchk++; if (kernel_job_addr !== 64'h1000) begin nerr++; $display("FAIL single_addr: got %0h want 1000", kernel_job_addr); end
        nchk++; if (queue_level !== 5'd0) begin nerr++; $display("FAIL single_popped: got %0d want 0", queue_level); end
        @(negedge clk);
        nchk++; if (kernel_start !== 8'h00) begin nerr++; $display("FAIL single_pulse_width: got %0h want 0", kernel_start); end
        nchk++; if (kernel_busy !== 8'h01) begin nerr++; $display("FAIL single_busy: got %0h want 01", kernel_busy); end
        nchk++; if (all_idle !== 1'b0) begin nerr++; $display("FAIL single_all_idle: got %0h want 0", all_idle); end
    endtask

    task automatic test_round_robin_nine();
        logic [7:0]  ks;
        logic [7:0]  exp_ks;
        logic [63:0] a;
        int          at;
        int          prev;
        bit          to;
        do_reset(8'h00);
        for (int i = 0; i < 9; i++) push_job(64'h2000 + 64'(i) * 64'h100);
        nchk++; if (queue_level !== 5'd9) begin nerr++; $display("FAIL rr9_level: got %0d want 9", queue_level); end
        manager_start = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            wait_start(ks, a, at, to);
            exp_ks = 8'h01 << i;
            nchk++;
            if (to) begin
                nerr++; $display("FAIL rr9_timeout_%0d: no start pulse within bound", i);
            end else begin
                if (ks !== exp_ks) begin nerr++; $display("FAIL rr9_start_%0d: got %0h want %0h", i, ks, exp_ks); end
                nchk++;
                if (a !== 64'h2000 + 64'(i) * 64'h100) begin nerr++; $display("FAIL rr9_addr_%0d: got %0h want %0h", i, a, 64'h2000 + 64'(i) * 64'h100); end
                if (i > 0) begin
                    nchk++;
                    if (at - prev !== 3) begin nerr++; $display("FAIL rr9_spacing_%0d: got %0d want 3", i, at - prev); end
                end
            end
            prev = at;
        end
        repeat (4) @(negedge clk);
        nchk++; if (queue_level !== 5'd1) begin nerr++; $display("FAIL rr9_waiting: got %0d want 1", queue_level); end
        nchk++; if (kernel_busy !== 8'hFF) begin nerr++; $display("FAIL rr9_all_busy: got %0h want ff", kernel_busy); end
        nchk++; if (jobs_done_cnt !== 32'd0) begin nerr++; $display("FAIL rr9_cnt0: got %0d want 0", jobs_done_cnt); end
        pulse_complete(8'h08);
        nchk++; if (kernel_busy !== 8'hF7) begin nerr++; $display("FAIL rr9_busy_clr: got %0h want f7", kernel_busy); end
        nchk++; if (jobs_done_cnt !== 32'd1) begin nerr++; $display("FAIL rr9_cnt1: got %0d want 1", jobs_done_cnt); end
        wait_start(ks, a, at, to);
        nchk++; if (to || ks !== 8'h08) begin nerr++; $display("FAIL rr9_ninth_start: got %0h want 08 (timeout %0d)", ks, to); end
        nchk++; if (a !== 64'h2800) begin nerr++; $display("FAIL rr9_ninth_addr: got %0h want 2800", a); end
        @(negedge clk);
        nchk++; if (queue_level !== 5'd0) begin nerr++; $display("FAIL rr9_drained: got %0d want 0", queue_level); end
        nchk++; if (kernel_busy !== 8'hFF) begin nerr++; $display("FAIL rr9_rebusy: got %0h want ff", kernel_busy); end
    endtask

    task automatic test_wrap();
        logic [7:0]  ks;
        logic [7:0]  exp_ks;
        logic [63:0] a;
        int          at;
        bit          to;
        do_reset(8'h00);
        for (int i = 0; i < 8; i++) push_job(64'h4000 + 64'(i));
        manager_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_start(ks, a, at, to);
            exp_ks = 8'h01 << i;
            nchk++; if (to || ks !== exp_ks) begin nerr++; $display("FAIL wrap_fill_%0d: got %0h want %0h", i, ks, exp_ks); end
        end
        @(negedge clk);
        // rr_ptr back at 0, everything busy; free kernels 1..4
        pulse_complete(8'h1E);
        nchk++; if (kernel_busy !== 8'hE1) begin nerr++; $display("FAIL wrap_busy_e1: got %0h want e1", kernel_busy); end
        nchk++; if (jobs_done_cnt !== 32'd4) begin nerr++; $display("FAIL wrap_cnt4: got %0d want 4", jobs_done_cnt); end
        manager_start = 1'b0;
        for (int i = 0; i < 4; i++) push_job(64'h4100 + 64'(i));
        manager_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(ks, a, at, to);
            exp_ks = 8'h02 << i;
            nchk++; if (to || ks !== exp_ks) begin nerr++; $display("FAIL wrap_skip0_%0d: got %0h want %0h", i, ks, exp_ks); end
        end
        @(negedge clk);
        // rr_ptr = 5 now; leave 0,5,6 busy
        pulse_complete(8'h9E);
        nchk++; if (kernel_busy !== 8'h61) begin nerr++; $display("FAIL wrap_busy_61: got %0h want 61", kernel_busy); end
        nchk++; if (jobs_done_cnt !== 32'd9) begin nerr++; $display("FAIL wrap_cnt9: got %0d want 9", jobs_done_cnt); end
        push_job(64'h4200);
        wait_start(ks, a, at, to);
        nchk++; if (to || ks !== 8'h80) begin nerr++; $display("FAIL wrap_grant7: got %0h want 80", ks); end
        nchk++; if (a !== 64'h4200) begin nerr++; $display("FAIL wrap_grant7_addr: got %0h want 4200", a); end
        @(negedge clk);
        nchk++; if (kernel_busy !== 8'hE1) begin nerr++; $display("FAIL wrap_busy_e1b: got %0h want e1", kernel_busy); end
        // rr_ptr wrapped to 0; kernel 0 and 7 busy, so kernel 1 is next
        pulse_complete(8'h60);
        nchk++; if (kernel_busy !== 8'h81) begin nerr++; $display("FAIL wrap_busy_81: got %0h want 81", kernel_busy); end
        push_job(64'h4300);
        wait_start(ks, a, at, to);
        nchk++; if (to || ks !== 8'h02) begin nerr++; $display("FAIL wrap_grant1: got %0h want 02", ks); end
        nchk++; if (jobs_done_cnt !== 32'd11) begin nerr++; $display("FAIL wrap_cnt11: got %0d want 11", jobs_done_cnt); end
    endtask

    task automatic test_full_queue();
        do_reset(8'h00);
        for (int i = 0; i < 16; i++) push_job(64'h3000 + 64'(i) * 64'h8);
        nchk++; if (job_ready !== 1'b0) begin nerr++; $display("FAIL full_ready: got %0h want 0", job_ready); end
        nchk++; if (queue_level !== 5'd16) begin nerr++; $display("FAIL full_level: got %0d want 16", queue_level); end
        nchk++; if (all_idle !== 1'b0) begin nerr++; $display("FAIL full_all_idle: got %0h want 0", all_idle); end
        push_job(64'hDEAD);
        nchk++; if (queue_level !== 5'd16) begin nerr++; $display("FAIL full_overflow: got %0d want 16", queue_level); end
        manager_start = 1'b1;
        @(negedge clk);
        nchk++; if (job_ready !== 1'b0) begin nerr++; $display("FAIL full_ready_grant: got %0h want 0", job_ready); end
        // Dropping enable mid-dispatch must not abort the in-flight grant
        manager_start = 1'b0;
        @(negedge clk);
        nchk++; if (kernel_start !== 8'h01) begin nerr++; $display("FAIL full_first_start: got %0h want 01", kernel_start); end
        nchk++; if (kernel_job_addr !== 64'h3000) begin nerr++; $display("FAIL full_first_addr: got %0h want 3000", kernel_job_addr); end
        nchk++; if (job_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_after_pop: got %0h want 1", job_ready); end
        nchk++; if (queue_level !== 5'd15) begin nerr++; $display("FAIL full_level_after_pop: got %0d want 15", queue_level); end
        repeat (4) @(negedge clk);
        nchk++; if (queue_level !== 5'd15) begin nerr++; $display("FAIL full_halted: got %0d want 15", queue_level); end
        nchk++; if (kernel_busy !== 8'h01) begin nerr++; $display("FAIL full_halted_busy: got %0h want 01", kernel_busy); end
    endtask

    task automatic test_multi_complete();
        logic [7:0]  ks;
        logic [7:0]  exp_ks;
        logic [63:0] a;
        int          at;
        bit          to;
        do_reset(8'h00);
        for (int i = 0; i < 5; i++) push_job(64'h6000 + 64'(i));
        manager_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_start(ks, a, at, to);
            exp_ks = 8'h01 << i;
            nchk++; if (to || ks !== exp_ks) begin nerr++; $display("FAIL multi_fill_%0d: got %0h want %0h", i, ks, exp_ks); end
        end
        @(negedge clk);
        nchk++; if (kernel_busy !== 8'h1F) begin nerr++; $display("FAIL multi_busy: got %0h want 1f", kernel_busy); end
        pulse_complete(8'h15);
        nchk++; if (jobs_done_cnt !== 32'd3) begin nerr++; $display("FAIL multi_cnt3: got %0d want 3", jobs_done_cnt); end
        nchk++; if (kernel_busy !== 8'h0A) begin nerr++; $display("FAIL multi_busy_clr: got %0h want 0a", kernel_busy); end
        // Edges on kernels without a job are ignored
        pulse_complete(8'h60);
        nchk++; if (jobs_done_cnt !== 32'd3) begin nerr++; $display("FAIL multi_idle_edge: got %0d want 3", jobs_done_cnt); end
        nchk++; if (kernel_busy !== 8'h0A) begin nerr++; $display("FAIL multi_idle_busy: got %0h want 0a", kernel_busy); end
        // Completion held high across reset produces no edge
        do_reset(8'hFF);
        repeat (3) @(negedge clk);
        nchk++; if (jobs_done_cnt !== 32'd0) begin nerr++; $display("FAIL held_cnt: got %0d want 0", jobs_done_cnt); end
        nchk++; if (kernel_busy !== 8'h00) begin nerr++; $display("FAIL held_busy: got %0h want 0", kernel_busy); end
        kernel_complete = 8'h00;
        @(negedge clk);
        nchk++; if (jobs_done_cnt !== 32'd0) begin nerr++; $display("FAIL held_fall: got %0d want 0", jobs_done_cnt); end
    endtask

    task automatic test_reset_in_grant();
        bit seen;
        do_reset(8'h00);
        manager_start = 1'b1;
        push_job(64'h5000);
        @(negedge clk);
        nchk++; if (queue_level !== 5'd1) begin nerr++; $display("FAIL rg_level_grant: got %0d want 1", queue_level); end
        rst = 1'b1;
        @(negedge clk);
        nchk++; if (kernel_start !== 8'h00) begin nerr++; $display("FAIL rg_no_pulse: got %0h want 0", kernel_start); end
        nchk++; if (queue_level !== 5'd0) begin nerr++; $display("FAIL rg_level: got %0d want 0", queue_level); end
        nchk++; if (all_idle !== 1'b1) begin nerr++; $display("FAIL rg_all_idle: got %0h want 1", all_idle); end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (kernel_start !== 8'h00) seen = 1'b1;
        end
        nchk++; if (seen !== 1'b0) begin nerr++; $display("FAIL rg_late_pulse: got %0h want 0", seen); end
        nchk++; if (kernel_busy !== 8'h00) begin nerr++; $display("FAIL rg_busy: got %0h want 0", kernel_busy); end
    endtask

    initial begin
        rst             = 1'b1;
        manager_start   = 1'b0;
        job_valid       = 1'b0;
        job_addr        = '0;
        kernel_complete = '0;
        @(negedge clk);
        test_reset();
        test_single_dispatch();
        test_round_robin_nine();
        test_wrap();
        test_full_queue();
        test_multi_complete();
        test_reset_in_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", nchk);
        $fatal(1, "watchdog expired");
    end

endmodule
